// File: rtl/memoria_navios.sv
// Two-bank ship-vector store for the Batalha Naval placement validator, with fill counters and a multi-cycle clear.
// Optional build macro MEMORIA_BYPASS_EN forwards an in-flight write to the combinational read port.
module memoria_navios #(
  parameter int NUM_SLOTS = 11,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrep1,
  input  logic              wrep2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] vetor,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              jogador,
  output logic [DATA_W-1:0] vetor_leitura,
  input  logic              limpar,
  output logic              ocupado,
  output logic [CNT_W-1:0]  cont_p1,
  output logic [CNT_W-1:0]  cont_p2,
  output logic              completo_p1,
  output logic              completo_p2,
  output logic              erro_escrita
);

  localparam int                SLOT_W    = $clog2(NUM_SLOTS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_SLOTS);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] LIMPANDO = 1'b1;

  logic [0:0]           state;
  logic [ADDR_W-1:0]    idx;
  logic [NUM_SLOTS-1:0] valid1, valid2;
  logic [DATA_W-1:0]    mem1 [NUM_SLOTS];
  logic [DATA_W-1:0]    mem2 [NUM_SLOTS];

  logic              wa_in, ra_in, idle_free, acc1, acc2, rejeita;
  logic [SLOT_W-1:0] wa, ra, ci;
  logic [CNT_W-1:0]  inc1, inc2;

  // wrepX is a single-cycle strobe with no back-pressure: a write is taken at
  // the edge only in IDLE with no clear request and an in-range address;
  // anything else is dropped and flagged on erro_escrita the following cycle.
  assign wa_in     = (write_addr <= LAST_ADDR);
  assign ra_in     = (read_addr <= LAST_ADDR);
  assign wa        = write_addr[SLOT_W-1:0];
  assign ra        = read_addr[SLOT_W-1:0];
  assign ci        = idx[SLOT_W-1:0];
  assign idle_free = (state == IDLE) && !limpar;
  assign acc1      = wrep1 && wa_in && idle_free;
  assign acc2      = wrep2 && wa_in && idle_free;
  assign rejeita   = (wrep1 || wrep2) && !(wa_in && idle_free);
  assign inc1      = CNT_W'(!valid1[wa]);
  assign inc2      = CNT_W'(!valid2[wa]);

  assign ocupado     = (state == LIMPANDO);
  assign completo_p1 = (cont_p1 == FULL_CNT);
  assign completo_p2 = (cont_p2 == FULL_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      valid1       <= '0;
      valid2       <= '0;
      cont_p1      <= '0;
      cont_p2      <= '0;
      erro_escrita <= 1'b0;
    end else begin
      erro_escrita <= rejeita;
      case (state)
        IDLE: begin
          if (limpar) begin
            // Valid bits drop immediately so the banks read empty while data is zeroed.
            state   <= LIMPANDO;
            idx     <= '0;
            valid1  <= '0;
            valid2  <= '0;
            cont_p1 <= '0;
            cont_p2 <= '0;
          end else begin
            if (acc1) begin
              valid1[wa] <= 1'b1;
              cont_p1    <= cont_p1 + inc1;
            end
            if (acc2) begin
              valid2[wa] <= 1'b1;
              cont_p2    <= cont_p2 + inc2;
            end
          end
        end
        default: begin
          if (idx == LAST_ADDR) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  // Storage carries no reset; stale contents are hidden by the valid bits.
  always_ff @(posedge clk) begin
    if (state == LIMPANDO) begin
      mem1[ci] <= '0;
      mem2[ci] <= '0;
    end else begin
      if (acc1) mem1[wa] <= vetor;
      if (acc2) mem2[wa] <= vetor;
    end
  end

  always_comb begin
    vetor_leitura = '0;
    if (ra_in && (state == IDLE)) begin
      if (jogador) begin
        if (valid2[ra]) vetor_leitura = mem2[ra];
      end else begin
        if (valid1[ra]) vetor_leitura = mem1[ra];
      end
    end
`ifdef MEMORIA_BYPASS_EN
    if (((acc1 && !jogador) || (acc2 && jogador)) && (read_addr == write_addr))
      vetor_leitura = vetor;
`endif
  end

endmodule

// File: tb/tb_memoria_navios.sv
// Directed self-checking bench for memoria_navios: reset, writes, overwrite, fill, reject, dual write, bypass, clear.
module tb_memoria_navios;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrep1, wrep2;
  logic [4:0]  write_addr;
  logic [63:0] vetor;
  logic [4:0]  read_addr;
  logic        jogador;
  logic [63:0] vetor_leitura;
  logic        limpar;
  logic        ocupado;
  logic [3:0]  cont_p1, cont_p2;
  logic        completo_p1, completo_p2;
  logic        erro_escrita;

  int n_checks = 0;
  int n_pass   = 0;

  memoria_navios dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wrep1         (wrep1),
    .wrep2         (wrep2),
    .write_addr    (write_addr),
    .vetor         (vetor),
    .read_addr     (read_addr),
    .jogador       (jogador),
    .vetor_leitura (vetor_leitura),
    .limpar        (limpar),
    .ocupado       (ocupado),
    .cont_p1       (cont_p1),
    .cont_p2       (cont_p2),
    .completo_p1   (completo_p1),
    .completo_p2   (completo_p2),
    .erro_escrita  (erro_escrita)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic b1, input logic b2, input logic [4:0] a, input logic [63:0] d);
    wrep1 = b1; wrep2 = b2; write_addr = a; vetor = d;
    step();
    wrep1 = 1'b0; wrep2 = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic j, input logic [4:0] a, input logic [63:0] exp);
    jogador = j; read_addr = a;
    #1;
    check(tag, vetor_leitura, exp);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; wrep1 = 1'b0; wrep2 = 1'b0; write_addr = '0; vetor = '0;
    read_addr = '0; jogador = 1'b0; limpar = 1'b0;
    step(); step();
    rst_n = 1'b1;

    // Reset state: every slot of both banks reads zero, including out-of-range 31.
    for (int i = 0; i < 11; i++) begin
      read_chk("rst_rd_b1", 1'b0, 5'(i), 64'h0);
      read_chk("rst_rd_b2", 1'b1, 5'(i), 64'h0);
    end
    read_chk("rst_rd_b1_31", 1'b0, 5'd31, 64'h0);
    read_chk("rst_rd_b2_31", 1'b1, 5'd31, 64'h0);
    check("rst_cont_p1", 64'(cont_p1), 64'd0);
    check("rst_cont_p2", 64'(cont_p2), 64'd0);
    check("rst_ocupado", 64'(ocupado), 64'd0);
    check("rst_erro", 64'(erro_escrita), 64'd0);

    // Single write to bank 1, then overwrite of the same slot.
    do_write(1'b1, 1'b0, 5'd3, 64'h0000_0000_0000_1C00);
    read_chk("wr_b1_rd3", 1'b0, 5'd3, 64'h0000_0000_0000_1C00);
    read_chk("wr_b1_rd3_b2", 1'b1, 5'd3, 64'h0);
    check("wr_b1_cont", 64'(cont_p1), 64'd1);
    do_write(1'b1, 1'b0, 5'd3, 64'h0000_0000_0000_1E00);
    read_chk("ovw_b1_rd3", 1'b0, 5'd3, 64'h0000_0000_0000_1E00);
    check("ovw_b1_cont", 64'(cont_p1), 64'd1);

    // Dual write lands in both banks; each counter advances.
    do_write(1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0055);
    read_chk("dual_rd_b1", 1'b0, 5'd5, 64'hDEAD_BEEF_0000_0055);
    read_chk("dual_rd_b2", 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0055);
    check("dual_cont_p1", 64'(cont_p1), 64'd2);
    check("dual_cont_p2", 64'(cont_p2), 64'd1);

    // Fill bank 2; slot 5 is already valid so the count lands on exactly 11.
    for (int i = 0; i < 11; i++) do_write(1'b0, 1'b1, 5'(i), 64'hA0 + 64'(i));
    check("fill_cont_p2", 64'(cont_p2), 64'd11);
    check("fill_completo_p2", 64'(completo_p2), 64'd1);
    check("fill_completo_p1", 64'(completo_p1), 64'd0);
    read_chk("fill_rd_b2_4", 1'b1, 5'd4, 64'hA4);
    read_chk("fill_rd_b2_10", 1'b1, 5'd10, 64'hAA);
    read_chk("fill_rd_b1_5", 1'b0, 5'd5, 64'hDEAD_BEEF_0000_0055);

    // Out-of-range write: one-cycle error pulse, no state change.
    do_write(1'b0, 1'b1, 5'd11, 64'hFFFF);
    check("oob_erro", 64'(erro_escrita), 64'd1);
    check("oob_cont_p2", 64'(cont_p2), 64'd11);
    step();
    check("oob_erro_drop", 64'(erro_escrita), 64'd0);

    // Same-cycle read of an in-flight write.
    wrep1 = 1'b1; write_addr = 5'd7; vetor = 64'h1234_5678_9ABC_DEF0;
    jogador = 1'b0; read_addr = 5'd7;
    #1;
`ifdef MEMORIA_BYPASS_EN
    check("bypass_pre_edge", vetor_leitura, 64'h1234_5678_9ABC_DEF0);
`else
    check("nobypass_pre_edge", vetor_leitura, 64'h0);
`endif
    step();
    wrep1 = 1'b0;
    read_chk("post_edge_rd7", 1'b0, 5'd7, 64'h1234_5678_9ABC_DEF0);
    check("post_edge_cont_p1", 64'(cont_p1), 64'd3);

    // Clear with a colliding write: clear wins, write is flagged.
    limpar = 1'b1; wrep1 = 1'b1; write_addr = 5'd0; vetor = 64'h77;
    step();
    limpar = 1'b0; wrep1 = 1'b0;
    check("clr_ocupado", 64'(ocupado), 64'd1);
    check("clr_cont_p1", 64'(cont_p1), 64'd0);
    check("clr_cont_p2", 64'(cont_p2), 64'd0);
    check("clr_completo_p2", 64'(completo_p2), 64'd0);
    check("clr_collide_erro", 64'(erro_escrita), 64'd1);
    read_chk("clr_rd_b1_3", 1'b0, 5'd3, 64'h0);
    cyc = 1;

    // Write during the clear sequence is rejected.
    do_write(1'b0, 1'b1, 5'd2, 64'h99);
    check("clr_wr_erro", 64'(erro_escrita), 64'd1);
    if (ocupado) cyc++;
    while (ocupado && cyc < 50) begin
      step();
      if (ocupado) cyc++;
    end
    check("clr_busy_cycles", 64'(cyc), 64'd11);
    check("clr_done_ocupado", 64'(ocupado), 64'd0);
    check("clr_done_cont_p1", 64'(cont_p1), 64'd0);
    check("clr_done_cont_p2", 64'(cont_p2), 64'd0);
    check("clr_done_erro", 64'(erro_escrita), 64'd0);
    read_chk("clr_done_b1_3", 1'b0, 5'd3, 64'h0);
    read_chk("clr_done_b1_5", 1'b0, 5'd5, 64'h0);
    read_chk("clr_done_b1_7", 1'b0, 5'd7, 64'h0);
    for (int i = 0; i < 11; i++) read_chk("clr_done_b2", 1'b1, 5'(i), 64'h0);

    // Storage works again after the clear.
    do_write(1'b0, 1'b1, 5'd2, 64'h4242);
    read_chk("after_clr_rd", 1'b1, 5'd2, 64'h4242);
    check("after_clr_cont_p2", 64'(cont_p2), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
